// File: rtl/can_pkg.sv
// can_pkg: shared types and constants for the CAN transmit path.
// Holds the frame sequencer state encoding and the fixed CAN frame
// geometry used by can_tx_stuff_ctrl.
package can_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STUFFED = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_TAIL    = 3'd3,
    ST_IFS     = 3'd4
  } tx_stuff_state_e;

  // Unstuffed recessive tail: CRC delimiter, ACK slot, ACK delimiter, 7-bit EOF.
  localparam int CAN_TAIL_BITS      = 10;
  // Intermission slots after EOF.
  localparam int CAN_IFS_BITS       = 3;
  // SOF, 11-bit ID, RTR, IDE, r0, 4-bit DLC, 64 data bits, 15-bit CRC.
  localparam int CAN_MAX_FRAME_BITS = 98;

  // Saturating increment for the 5-bit stuff-bit counter.
  function automatic logic [4:0] sat_inc5(input logic [4:0] val);
    if (val == 5'd31) begin
      return val;
    end
    return val + 5'd1;
  endfunction

endpackage

// File: rtl/can_tx_stuff_ctrl.sv
// can_tx_stuff_ctrl: frame-level transmit sequencer in front of the CAN bit
// stuffer. Feeds the latched stuffed region MSB-first to the stuffer, holds
// the current bit while the stuffer inserts a stuff bit, then appends the
// recessive tail and, optionally, the intermission.
// Optional feature macro: CAN_TX_STUFF_CTRL_IFS_EN (adds the 3-slot IFS state).
module can_tx_stuff_ctrl
  import can_pkg::*;
#(
  parameter int MAX_BITS = CAN_MAX_FRAME_BITS,
  parameter int LEN_W    = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_point,
  input  logic                frame_valid,
  output logic                frame_ready,
  input  logic [MAX_BITS-1:0] frame_bits,
  input  logic [LEN_W-1:0]    frame_len,
  input  logic                tx_abort,
  output logic                stf_bit_in,
  input  logic                stf_bit_out,
  input  logic                stf_stuff_inserted,
  output logic                tx_bit,
  output logic                busy,
  output logic                done,
  output logic [4:0]          stuff_cnt
);

  tx_stuff_state_e     state_q, state_d;
  logic [MAX_BITS-1:0] frame_q, frame_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    bit_idx_q, bit_idx_d;
  logic [4:0]          stuff_cnt_q, stuff_cnt_d;
  logic [3:0]          tail_cnt_q, tail_cnt_d;
  logic                done_q, done_d;
`ifdef CAN_TX_STUFF_CTRL_IFS_EN
  logic [1:0]          ifs_cnt_q, ifs_cnt_d;
`endif

  logic [LEN_W-1:0]    bit_pos;
  logic [LEN_W-1:0]    bit_idx_inc;

  // Position of the current bit inside the left-aligned frame vector.
  assign bit_pos     = LEN_W'(MAX_BITS - 1) - bit_idx_q;
  assign bit_idx_inc = bit_idx_q + LEN_W'(1);

  assign frame_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign stuff_cnt   = stuff_cnt_q;

  // State and datapath registers; reset returns everything to the idle frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      frame_q     <= '0;
      len_q       <= '0;
      bit_idx_q   <= '0;
      stuff_cnt_q <= '0;
      tail_cnt_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      len_q       <= len_d;
      bit_idx_q   <= bit_idx_d;
      stuff_cnt_q <= stuff_cnt_d;
      tail_cnt_q  <= tail_cnt_d;
      done_q      <= done_d;
    end
  end

`ifdef CAN_TX_STUFF_CTRL_IFS_EN
  // Intermission slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifs_cnt_q <= '0;
    end else begin
      ifs_cnt_q <= ifs_cnt_d;
    end
  end
`endif

  // Next-state and output logic; slot activity only advances on sample points,
  // while accept and abort act on any edge.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    len_d       = len_q;
    bit_idx_d   = bit_idx_q;
    stuff_cnt_d = stuff_cnt_q;
    tail_cnt_d  = tail_cnt_q;
    done_d      = 1'b0;
`ifdef CAN_TX_STUFF_CTRL_IFS_EN
    ifs_cnt_d   = ifs_cnt_q;
`endif
    stf_bit_in  = 1'b1;
    tx_bit      = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (frame_valid) begin
          frame_d     = frame_bits;
          len_d       = frame_len;
          bit_idx_d   = '0;
          stuff_cnt_d = '0;
          state_d     = ST_STUFFED;
        end
      end

      ST_STUFFED: begin
        stf_bit_in = frame_q[bit_pos];
        tx_bit     = stf_bit_out;
        if (sample_point) begin
          if (stf_stuff_inserted) begin
            // The stuffer used this slot; the current bit is offered again.
            stuff_cnt_d = sat_inc5(stuff_cnt_q);
          end else begin
            bit_idx_d = bit_idx_inc;
            if (bit_idx_inc == len_q) begin
              state_d = ST_DRAIN;
            end
          end
        end
      end

      ST_DRAIN: begin
        // A stuff bit may still be due after the last CRC bit; if so it
        // occupies this slot and the CRC delimiter moves into the tail.
        tx_bit = stf_bit_out;
        if (sample_point) begin
          if (stf_stuff_inserted) begin
            stuff_cnt_d = sat_inc5(stuff_cnt_q);
            tail_cnt_d  = 4'(CAN_TAIL_BITS);
          end else begin
            tail_cnt_d  = 4'(CAN_TAIL_BITS - 1);
          end
          state_d = ST_TAIL;
        end
      end

      ST_TAIL: begin
        if (sample_point) begin
          tail_cnt_d = tail_cnt_q - 4'd1;
          if (tail_cnt_q == 4'd1) begin
`ifdef CAN_TX_STUFF_CTRL_IFS_EN
            ifs_cnt_d = 2'(CAN_IFS_BITS);
            state_d   = ST_IFS;
`else
            done_d    = 1'b1;
            state_d   = ST_IDLE;
`endif
          end
        end
      end

`ifdef CAN_TX_STUFF_CTRL_IFS_EN
      ST_IFS: begin
        if (sample_point) begin
          ifs_cnt_d = ifs_cnt_q - 2'd1;
          if (ifs_cnt_q == 2'd1) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over any slot transition and keeps the stuff count as it was.
    if (tx_abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      stuff_cnt_d = stuff_cnt_q;
      done_d      = 1'b0;
    end
  end

endmodule

// File: tb/tb_can_tx_stuff_ctrl.sv
// tb_can_tx_stuff_ctrl: directed bench for can_tx_stuff_ctrl with a
// behavioural stand-in for the CAN bit stuffer.
// Honours CAN_TX_STUFF_CTRL_IFS_EN for the expected frame length.
module tb_can_tx_stuff_ctrl;

`ifdef CAN_TX_STUFF_CTRL_IFS_EN
  localparam int IFS_SLOTS = 3;
`else
  localparam int IFS_SLOTS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_point = 1'b0;
  logic        frame_valid = 1'b0;
  logic [97:0] frame_bits = '0;
  logic [6:0]  frame_len = '0;
  logic        tx_abort = 1'b0;
  logic        frame_ready;
  logic        stf_bit_in;
  logic        stf_bit_out;
  logic        stf_stuff_inserted;
  logic        tx_bit;
  logic        busy;
  logic        done;
  logic [4:0]  stuff_cnt;

  int total = 0;
  int bad = 0;

  logic txLog  [0:127];
  logic stfLog [0:127];

  // Stuffer stand-in: after five equal bus bits the next slot is a stuff bit.
  logic       stfLast;
  logic [2:0] stfRun;

  always #5 clk = ~clk;

  can_tx_stuff_ctrl #(.MAX_BITS(98), .LEN_W(7)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sample_point      (sample_point),
    .frame_valid       (frame_valid),
    .frame_ready       (frame_ready),
    .frame_bits        (frame_bits),
    .frame_len         (frame_len),
    .tx_abort          (tx_abort),
    .stf_bit_in        (stf_bit_in),
    .stf_bit_out       (stf_bit_out),
    .stf_stuff_inserted(stf_stuff_inserted),
    .tx_bit            (tx_bit),
    .busy              (busy),
    .done              (done),
    .stuff_cnt         (stuff_cnt)
  );

  assign stf_stuff_inserted = busy && (stfRun == 3'd5);
  assign stf_bit_out        = stf_stuff_inserted ? ~stfLast : stf_bit_in;

  // Track the run of equal bus bits; cleared whenever the sequencer is idle.
  always @(posedge clk) begin
    if (!busy) begin
      stfLast <= 1'b1;
      stfRun  <= 3'd0;
    end else if (sample_point) begin
      if (stf_stuff_inserted) begin
        stfLast <= ~stfLast;
        stfRun  <= 3'd1;
      end else if (stf_bit_in == stfLast) begin
        stfRun  <= stfRun + 3'd1;
      end else begin
        stfLast <= stf_bit_in;
        stfRun  <= 3'd1;
      end
    end
  end

  // One clock edge, optionally a sample point; outputs settle 1 ns later.
  task automatic cycle(input logic sp);
    sample_point = sp;
    @(posedge clk);
    #1;
    sample_point = 1'b0;
  endtask

  task automatic start_frame(input logic [97:0] bits, input logic [6:0] len);
    frame_bits  = bits;
    frame_len   = len;
    frame_valid = 1'b1;
    cycle(1'b0);
    frame_valid = 1'b0;
  endtask

  // Step slot by slot, logging tx_bit and stf_bit_in; stops on done, after
  // stopAfter slots (when nonzero) or at the slot budget.
  task automatic run_slots(input int maxSlots, input int stopAfter, input int intrudeSlot,
                           output int nSlots, output bit gotDone);
    gotDone = 1'b0;
    nSlots  = 0;
    for (int s = 0; s < maxSlots; s++) begin
      if (stopAfter > 0 && s == stopAfter) break;
      if (s == intrudeSlot) begin
        frame_bits  = '0;
        frame_len   = 7'd8;
        frame_valid = 1'b1;
      end
      cycle(1'b0);
      frame_valid = 1'b0;
      txLog[s]  = tx_bit;
      stfLog[s] = stf_bit_in;
      cycle(1'b1);
      nSlots = s + 1;
      if (done === 1'b1) begin
        gotDone = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cycle(1'b0);
    total++; if (frame_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", frame_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    total++; if (tx_bit !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx: got %b want 1", tx_bit); end
    total++; if (stf_bit_in !== 1'b1) begin bad++; $display("[TB] FAIL reset_stf_in: got %b want 1", stf_bit_in); end
    total++; if (stuff_cnt !== 5'd0) begin bad++; $display("[TB] FAIL reset_stuff_cnt: got %0d want 0", stuff_cnt); end
    rst_n = 1'b1;
    repeat (2) cycle(1'b0);
  endtask

  task automatic test_alternating();
    logic [97:0] bits;
    int n;
    bit gd;
    logic expTx;
    bits = '0;
    for (int i = 0; i < 20; i++) bits[97-i] = 1'(i % 2);
    start_frame(bits, 7'd20);
    total++; if (stf_bit_in !== 1'b0) begin bad++; $display("[TB] FAIL alt_sof_presented: got %b want 0", stf_bit_in); end
    run_slots(100, 0, -1, n, gd);
    total++; if (gd !== 1'b1) begin bad++; $display("[TB] FAIL alt_done_seen: got %b want 1", gd); end
    total++; if (n != 30 + IFS_SLOTS) begin bad++; $display("[TB] FAIL alt_slots: got %0d want %0d", n, 30 + IFS_SLOTS); end
    total++; if (stuff_cnt !== 5'd0) begin bad++; $display("[TB] FAIL alt_stuff_cnt: got %0d want 0", stuff_cnt); end
    for (int i = 0; i < n; i++) begin
      expTx = (i < 20) ? 1'(i % 2) : 1'b1;
      total++; if (txLog[i] !== expTx) begin bad++; $display("[TB] FAIL alt_tx slot %0d: got %b want %b", i, txLog[i], expTx); end
    end
    total++; if (frame_ready !== 1'b1) begin bad++; $display("[TB] FAIL alt_ready_after: got %b want 1", frame_ready); end
    cycle(1'b0);
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL alt_done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_stuff_insert();
    logic [97:0] bits;
    int n;
    bit gd;
    logic expTx;
    bits = '0;
    for (int i = 5; i < 8; i++) bits[97-i] = 1'b1;
    start_frame(bits, 7'd8);
    run_slots(100, 0, -1, n, gd);
    total++; if (gd !== 1'b1) begin bad++; $display("[TB] FAIL stuff_done_seen: got %b want 1", gd); end
    total++; if (n != 19 + IFS_SLOTS) begin bad++; $display("[TB] FAIL stuff_slots: got %0d want %0d", n, 19 + IFS_SLOTS); end
    total++; if (stuff_cnt !== 5'd1) begin bad++; $display("[TB] FAIL stuff_cnt: got %0d want 1", stuff_cnt); end
    for (int i = 0; i < n; i++) begin
      expTx = (i < 5) ? 1'b0 : 1'b1;
      total++; if (txLog[i] !== expTx) begin bad++; $display("[TB] FAIL stuff_tx slot %0d: got %b want %b", i, txLog[i], expTx); end
    end
    for (int i = 0; i < 10; i++) begin
      expTx = (i < 5) ? 1'b0 : 1'b1;
      total++; if (stfLog[i] !== expTx) begin bad++; $display("[TB] FAIL stuff_stf_in slot %0d: got %b want %b", i, stfLog[i], expTx); end
    end
    cycle(1'b0);
  endtask

  task automatic test_drain_stuff();
    logic [97:0] bits;
    int n;
    bit gd;
    logic expTx;
    bits = '0;
    for (int i = 0; i < 34; i++) bits[97-i] = (i < 29) ? 1'(i % 2) : 1'b1;
    start_frame(bits, 7'd34);
    run_slots(100, 0, -1, n, gd);
    total++; if (gd !== 1'b1) begin bad++; $display("[TB] FAIL drain_done_seen: got %b want 1", gd); end
    total++; if (n != 45 + IFS_SLOTS) begin bad++; $display("[TB] FAIL drain_slots: got %0d want %0d", n, 45 + IFS_SLOTS); end
    total++; if (stuff_cnt !== 5'd1) begin bad++; $display("[TB] FAIL drain_stuff_cnt: got %0d want 1", stuff_cnt); end
    for (int i = 0; i < n; i++) begin
      if (i < 29) expTx = 1'(i % 2);
      else if (i < 34) expTx = 1'b1;
      else if (i == 34) expTx = 1'b0;
      else expTx = 1'b1;
      total++; if (txLog[i] !== expTx) begin bad++; $display("[TB] FAIL drain_tx slot %0d: got %b want %b", i, txLog[i], expTx); end
    end
    cycle(1'b0);
  endtask

  task automatic test_abort();
    logic [97:0] bits;
    int n;
    bit gd;
    int doneSeen;
    bits = '0;
    for (int i = 5; i < 20; i++) bits[97-i] = 1'(i % 2);
    start_frame(bits, 7'd20);
    run_slots(100, 13, -1, n, gd);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL abort_busy_before: got %b want 1", busy); end
    cycle(1'b0);
    tx_abort = 1'b1;
    cycle(1'b1);
    tx_abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    total++; if (frame_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_ready: got %b want 1", frame_ready); end
    total++; if (tx_bit !== 1'b1) begin bad++; $display("[TB] FAIL abort_tx: got %b want 1", tx_bit); end
    total++; if (stuff_cnt !== 5'd1) begin bad++; $display("[TB] FAIL abort_stuff_cnt: got %0d want 1", stuff_cnt); end
    doneSeen = (done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1);
      if (done === 1'b1) doneSeen++;
    end
    total++; if (doneSeen != 0) begin bad++; $display("[TB] FAIL abort_no_done: got %0d pulses want 0", doneSeen); end
  endtask

  task automatic test_reset_mid_tail();
    logic [97:0] bits;
    int n;
    bit gd;
    bits = '0;
    for (int i = 5; i < 8; i++) bits[97-i] = 1'b1;
    start_frame(bits, 7'd8);
    run_slots(100, 14, -1, n, gd);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rst_busy_before: got %b want 1", busy); end
    total++; if (stuff_cnt !== 5'd1) begin bad++; $display("[TB] FAIL rst_stuff_cnt_before: got %0d want 1", stuff_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    total++; if (frame_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready: got %b want 1", frame_ready); end
    total++; if (tx_bit !== 1'b1) begin bad++; $display("[TB] FAIL rst_tx: got %b want 1", tx_bit); end
    total++; if (stuff_cnt !== 5'd0) begin bad++; $display("[TB] FAIL rst_stuff_cnt: got %0d want 0", stuff_cnt); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL rst_done: got %b want 0", done); end
    cycle(1'b0);
    rst_n = 1'b1;
    cycle(1'b0);
    start_frame(bits, 7'd8);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rst_reaccept: got %b want 1", busy); end
    run_slots(100, 0, -1, n, gd);
    total++; if (gd !== 1'b1) begin bad++; $display("[TB] FAIL rst_refr_done: got %b want 1", gd); end
    total++; if (n != 19 + IFS_SLOTS) begin bad++; $display("[TB] FAIL rst_refr_slots: got %0d want %0d", n, 19 + IFS_SLOTS); end
    total++; if (stuff_cnt !== 5'd1) begin bad++; $display("[TB] FAIL rst_refr_stuff_cnt: got %0d want 1", stuff_cnt); end
    cycle(1'b0);
  endtask

  task automatic test_valid_while_busy();
    logic [97:0] bits;
    int n;
    bit gd;
    logic expTx;
    bits = '0;
    for (int i = 0; i < 20; i++) bits[97-i] = 1'(i % 2);
    start_frame(bits, 7'd20);
    total++; if (frame_ready !== 1'b0) begin bad++; $display("[TB] FAIL busy_ready_low: got %b want 0", frame_ready); end
    run_slots(100, 0, 5, n, gd);
    total++; if (gd !== 1'b1) begin bad++; $display("[TB] FAIL busy_done_seen: got %b want 1", gd); end
    total++; if (n != 30 + IFS_SLOTS) begin bad++; $display("[TB] FAIL busy_slots: got %0d want %0d", n, 30 + IFS_SLOTS); end
    total++; if (stuff_cnt !== 5'd0) begin bad++; $display("[TB] FAIL busy_stuff_cnt: got %0d want 0", stuff_cnt); end
    for (int i = 0; i < n; i++) begin
      expTx = (i < 20) ? 1'(i % 2) : 1'b1;
      total++; if (txLog[i] !== expTx) begin bad++; $display("[TB] FAIL busy_tx slot %0d: got %b want %b", i, txLog[i], expTx); end
    end
    cycle(1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_idle_after: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_stuff_insert();
    test_drain_stuff();
    test_abort();
    test_reset_mid_tail();
    test_valid_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
